// File: rtl/mc_pkg.sv
// Shared types for the DRAM command path: request ops, DIMM commands, address field map, timing defaults.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package mc_pkg;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_IFETCH = 2'd2,
        OP_RSVD   = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4
    } cmd_t;

    // Physical address map (33-bit address, byte offset addr[1:0] is dropped).
    localparam int ADDR_W   = 33;
    localparam int ROW_W    = 16;
    localparam int COL_W    = 10;
    localparam int BA_W     = 2;
    localparam int BG_W     = 3;
    localparam int ROW_LSB  = 17;
    localparam int COLH_LSB = 11;
    localparam int COLH_W   = 6;
    localparam int COLL_LSB = 2;
    localparam int COLL_W   = 4;
    localparam int BA_LSB   = 9;
    localparam int BG_LSB   = 6;

    // Timing defaults, in DIMM cycles (one DIMM cycle = two clk cycles).
    localparam int T_RCD_DEF   = 39;
    localparam int T_CL_DEF    = 40;
    localparam int T_CWL_DEF   = 38;
    localparam int T_BURST_DEF = 8;
    localparam int T_RP_DEF    = 39;

    typedef struct packed {
        logic [BG_W-1:0]  bg;
        logic [BA_W-1:0]  ba;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } dram_addr_t;

    // Column is split in the address: high part above the bank bits, low part below the bank group.
    function automatic dram_addr_t decode_addr(input logic [ADDR_W-1:COLL_LSB] a);
        dram_addr_t d;
        d.row = a[ROW_LSB +: ROW_W];
        d.col = {a[COLH_LSB +: COLH_W], a[COLL_LSB +: COLL_W]};
        d.ba  = a[BA_LSB +: BA_W];
        d.bg  = a[BG_LSB +: BG_W];
        return d;
    endfunction

    // Counter width able to hold the longest load value without wrapping.
    function automatic int timer_width(input int rcd, input int cl, input int cwl,
                                       input int burst, input int rp);
        int m;
        m = ((cl > cwl) ? cl : cwl) + burst;
        if (rcd > m) m = rcd;
        if (rp > m) m = rp;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dimm_timer.sv
// Loadable down-counter that only counts on DIMM ticks; zero flag reflects the current count.
// Latency: load visible on zero the clk after load; one decrement per tick, saturating at 0.
// Backpressure: none; load takes priority over counting.
// Ports: clk/rst, tick (count enable), load/load_val (synchronous reload), zero (count==0).
module dimm_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dram_cmd_sched.sv
// Closed-page DRAM command scheduler: one request -> ACT, RD|WR, PRE on DIMM ticks (every 2nd clk).
// Latency: ACT on the first tick after acceptance; RD/WR T_RCD ticks later; PRE T_CL|T_CWL+T_BURST after.
// Backpressure: req_ready only in IDLE; one request outstanding, entries wait upstream otherwise.
// Ports: req_valid/req_ready/req_op/req_addr (request in), cmd_valid/cmd/cmd_bg/ba/row/col (DIMM
//        command out, fields hold between strobes), busy (any state other than IDLE).
module dram_cmd_sched
    import mc_pkg::*;
#(
    parameter int T_RCD   = T_RCD_DEF,
    parameter int T_CL    = T_CL_DEF,
    parameter int T_CWL   = T_CWL_DEF,
    parameter int T_BURST = T_BURST_DEF,
    parameter int T_RP    = T_RP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              cmd_valid,
    output cmd_t              cmd,
    output logic [BG_W-1:0]   cmd_bg,
    output logic [BA_W-1:0]   cmd_ba,
    output logic [ROW_W-1:0]  cmd_row,
    output logic [COL_W-1:0]  cmd_col,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACT,
        S_WAIT_RCD,
        S_RDWR,
        S_WAIT_DATA,
        S_PRE,
        S_WAIT_RP
    } state_t;

    localparam int TW = timer_width(T_RCD, T_CL, T_CWL, T_BURST, T_RP);

    // Waits load N-1: the counter reaches zero on the (N-1)th tick, the FSM leaves the wait state
    // on the following off-tick edge, and the next command lands on the Nth tick.
    localparam logic [TW-1:0] LD_RCD = TW'(T_RCD - 1);
    localparam logic [TW-1:0] LD_RD  = TW'(T_CL + T_BURST - 1);
    localparam logic [TW-1:0] LD_WR  = TW'(T_CWL + T_BURST - 1);
    localparam logic [TW-1:0] LD_RP  = TW'(T_RP - 1);

    state_t     state, state_nxt;
    logic       phase;
    logic       started;
    logic       tick;
    logic       accept;
    logic       req_wr;
    dram_addr_t fld;

    logic          fire;
    cmd_t          cmd_nxt;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;

    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[COLL_LSB-1:0];

    // Phase 0 is a tick, so the first edge after reset release is a tick edge.
    assign tick = ~phase;

    // started keeps req_ready low until the first edge after reset release.
    assign req_ready = started && (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = req_valid && req_ready;

    dimm_timer #(
        .W(TW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fire      = 1'b0;
        cmd_nxt   = CMD_NOP;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_ACT;
            end
            S_ACT: begin
                if (tick) begin
                    fire      = 1'b1;
                    cmd_nxt   = CMD_ACT;
                    tmr_load  = 1'b1;
                    tmr_val   = LD_RCD;
                    state_nxt = S_WAIT_RCD;
                end
            end
            S_WAIT_RCD: begin
                if (tmr_zero) state_nxt = S_RDWR;
            end
            S_RDWR: begin
                if (tick) begin
                    fire      = 1'b1;
                    cmd_nxt   = req_wr ? CMD_WR : CMD_RD;
                    tmr_load  = 1'b1;
                    tmr_val   = req_wr ? LD_WR : LD_RD;
                    state_nxt = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (tmr_zero) state_nxt = S_PRE;
            end
            S_PRE: begin
                if (tick) begin
                    fire      = 1'b1;
                    cmd_nxt   = CMD_PRE;
                    tmr_load  = 1'b1;
                    tmr_val   = LD_RP;
                    state_nxt = S_WAIT_RP;
                end
            end
            S_WAIT_RP: begin
                if (tmr_zero) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= 1'b0;
            started   <= 1'b0;
            req_wr    <= 1'b0;
            fld       <= '0;
            cmd_valid <= 1'b0;
            cmd       <= CMD_NOP;
            cmd_bg    <= '0;
            cmd_ba    <= '0;
            cmd_row   <= '0;
            cmd_col   <= '0;
        end else begin
            phase     <= ~phase;
            started   <= 1'b1;
            cmd_valid <= fire;
            cmd       <= cmd_nxt;
            if (accept) begin
                // Op 3 is not a write, so it falls into the read path with ops 0 and 2.
                req_wr <= (req_op == OP_WRITE);
                fld    <= decode_addr(req_addr[ADDR_W-1:COLL_LSB]);
            end
            // Only the fields a command carries are refreshed; the rest hold their last value.
            if (fire) begin
                cmd_bg <= fld.bg;
                cmd_ba <= fld.ba;
                case (cmd_nxt)
                    CMD_ACT:        cmd_row <= fld.row;
                    CMD_RD, CMD_WR: cmd_col <= fld.col;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Bench for dram_cmd_sched: event-schedule model checked every cycle plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_dram_cmd_sched;
    import mc_pkg::*;

    localparam int P_RCD   = 2;
    localparam int P_CL    = 3;
    localparam int P_CWL   = 2;
    localparam int P_BURST = 2;
    localparam int P_RP    = 2;

    localparam logic [32:0] ADDR_A = 33'h014A2ACC;
    localparam logic [32:0] ADDR_B = 33'h1FFFFFFFC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  req_op = 2'd0;
    logic [32:0] req_addr = '0;
    logic        req_ready;
    logic        cmd_valid;
    cmd_t        cmd;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        busy;

    always #5 clk = ~clk;

    dram_cmd_sched #(
        .T_RCD(P_RCD), .T_CL(P_CL), .T_CWL(P_CWL), .T_BURST(P_BURST), .T_RP(P_RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_bg    (cmd_bg),
        .cmd_ba    (cmd_ba),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .busy      (busy)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_assert++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // ---------------- model: per-request command schedule in clk-edge numbers ----------------
    // edge_n counts clk edges since reset release (0 = first edge, a tick; ticks are even edges).
    int          edge_n = -1;
    int          acc_e  = -100;
    int          act_e  = -100;
    int          rd_e   = -100;
    int          pre_e  = -100;
    int          free_e = 0;       // req_ready is high after this edge
    bit          m_wr;
    logic [2:0]  p_bg,  m_bg;
    logic [1:0]  p_ba,  m_ba;
    logic [15:0] p_row, m_row;
    logic [9:0]  p_col, m_col;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_n = -1; acc_e = -100; act_e = -100; rd_e = -100; pre_e = -100; free_e = 0;
            m_wr = 0;
            p_bg = 0; p_ba = 0; p_row = 0; p_col = 0;
            m_bg = 0; m_ba = 0; m_row = 0; m_col = 0;
        end else begin
            edge_n++;
            if (req_valid && (edge_n - 1 >= free_e)) begin
                acc_e  = edge_n;
                act_e  = ((edge_n % 2) == 0) ? edge_n + 2 : edge_n + 1;
                m_wr   = (req_op == 2'd1);
                rd_e   = act_e + 2 * P_RCD;
                pre_e  = rd_e + 2 * ((m_wr ? P_CWL : P_CL) + P_BURST);
                free_e = pre_e + 2 * P_RP - 1;
                p_row  = req_addr[32:17];
                p_col  = {req_addr[16:11], req_addr[5:2]};
                p_ba   = req_addr[10:9];
                p_bg   = req_addr[8:6];
            end
            if (edge_n == act_e) begin m_bg = p_bg; m_ba = p_ba; m_row = p_row; end
            if (edge_n == rd_e)  begin m_bg = p_bg; m_ba = p_ba; m_col = p_col; end
            if (edge_n == pre_e) begin m_bg = p_bg; m_ba = p_ba; end
        end
    end

    // ---------------- compare every cycle ----------------
    always @(negedge clk) begin
        logic [2:0] ec;
        logic       ebusy, erdy;
        ec = CMD_NOP; ebusy = 1'b0; erdy = 1'b0;
        if (!rst && edge_n >= 0) begin
            if (edge_n == act_e)      ec = CMD_ACT;
            else if (edge_n == rd_e)  ec = m_wr ? CMD_WR : CMD_RD;
            else if (edge_n == pre_e) ec = CMD_PRE;
            ebusy = (edge_n >= acc_e) && (edge_n < free_e);
            erdy  = !ebusy;
        end
        check("ctrl{valid,cmd,busy,ready}", {cmd_valid, 3'(cmd), busy, req_ready},
              {(ec != 3'(CMD_NOP)), ec, ebusy, erdy});
        check("fields{bg,ba,row,col}", {cmd_bg, cmd_ba, cmd_row, cmd_col},
              {m_bg, m_ba, m_row, m_col});
    end

    // ---------------- command log ----------------
    int          log_e[$];
    int          log_c[$];
    logic [2:0]  log_bg[$];
    logic [1:0]  log_ba[$];
    logic [15:0] log_row[$];
    logic [9:0]  log_col[$];

    always @(negedge clk) begin
        if (!rst && cmd_valid) begin
            log_e.push_back(edge_n);
            log_c.push_back(int'(cmd));
            log_bg.push_back(cmd_bg);
            log_ba.push_back(cmd_ba);
            log_row.push_back(cmd_row);
            log_col.push_back(cmd_col);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [32:0] a, input bit keep, output int acc);
        int n;
        n = 0;
        req_valid = 1'b1; req_op = op; req_addr = a;
        while (!req_ready && n < 200) begin step(); n++; end
        if (!req_ready) begin
            fail_now("send_accept");
            req_valid = 1'b0;
            acc = -1;
        end else begin
            step();
            acc = edge_n;
            req_valid = keep;
            req_addr  = ~a;
            req_op    = ~op;
        end
    endtask

    task automatic wait_log(input int target, input bit need_ready, input string name);
        int n;
        n = 0;
        while ((log_e.size() < target || (need_ready && !req_ready)) && n < 400) begin
            step(); n++;
        end
        if (log_e.size() < target || (need_ready && !req_ready)) fail_now(name);
    endtask

    initial begin
        int acc, acc2, base;
        repeat (3) step();
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd", cmd, CMD_NOP);
        check("rst_cmd_valid", cmd_valid, 0);
        rst = 1'b0;
        #1 check("ready_before_first_edge", req_ready, 0);
        step();
        check("ready_after_first_edge", req_ready, 1);

        // read, accepted on edge 1 (odd) -> ACT on edge 2
        base = log_e.size();
        send(2'd0, ADDR_A, 1'b0, acc);
        wait_log(base + 3, 1'b1, "read_done");
        if (log_e.size() >= base + 3) begin
            check("rd_acc_edge", acc, 1);
            check("rd_act_edge", log_e[base], 2);
            check("rd_seq0", log_c[base], CMD_ACT);
            check("rd_seq1", log_c[base+1], CMD_RD);
            check("rd_seq2", log_c[base+2], CMD_PRE);
            check("rd_act_bg", log_bg[base], 3);
            check("rd_act_ba", log_ba[base], 1);
            check("rd_act_row", log_row[base], 16'h00A5);
            check("rd_col", log_col[base+1], 10'h053);
            check("rd_gap_act_rd", log_e[base+1] - log_e[base], 4);
            check("rd_gap_rd_pre", log_e[base+2] - log_e[base+1], 10);
            check("rd_pulses", log_e.size() - base, 3);
        end

        // write, same address
        base = log_e.size();
        send(2'd1, ADDR_A, 1'b0, acc);
        wait_log(base + 3, 1'b1, "write_done");
        if (log_e.size() >= base + 3) begin
            check("wr_seq1", log_c[base+1], CMD_WR);
            check("wr_act_even", log_e[base] % 2, 0);
            check("wr_gap_act_wr", log_e[base+1] - log_e[base], 4);
            check("wr_gap_wr_pre", log_e[base+2] - log_e[base+1], 8);
            check("wr_pulses", log_e.size() - base, 3);
        end

        // ifetch accepted on an even edge -> ACT two edges later
        while ((edge_n % 2) != 1) step();
        base = log_e.size();
        send(2'd2, ADDR_B, 1'b0, acc);
        wait_log(base + 3, 1'b1, "ifetch_done");
        if (log_e.size() >= base + 3) begin
            check("if_acc_even", acc % 2, 0);
            check("if_act_edge", log_e[base] - acc, 2);
            check("if_cmd_rd", log_c[base+1], CMD_RD);
            check("if_col", log_col[base+1], 10'h3FF);
            check("if_row", log_row[base], 16'hFFFF);
        end

        // op 3 behaves as read
        base = log_e.size();
        send(2'd3, ADDR_A, 1'b0, acc);
        wait_log(base + 3, 1'b1, "op3_done");
        if (log_e.size() >= base + 3) check("op3_cmd_rd", log_c[base+1], CMD_RD);

        // back-to-back: valid held high across two entries
        base = log_e.size();
        send(2'd0, ADDR_A, 1'b1, acc);
        send(2'd1, ADDR_B, 1'b0, acc2);
        wait_log(base + 6, 1'b1, "b2b_done");
        if (log_e.size() >= base + 6) begin
            check("b2b_seq", {log_c[base+2], log_c[base+3], log_c[base+4]},
                  {32'(CMD_PRE), 32'(CMD_ACT), 32'(CMD_WR)});
            check("b2b_gap_ge_trp", (log_e[base+3] - log_e[base+2]) >= 2 * P_RP, 1);
            check("b2b_acc2_after_pre", acc2 > log_e[base+2], 1);
            check("b2b_bg2", log_bg[base+3], 7);
        end

        // reset during WAIT_DATA
        base = log_e.size();
        send(2'd0, ADDR_A, 1'b0, acc);
        wait_log(base + 2, 1'b0, "rst_rd_seen");
        step(); step();
        rst = 1'b1;
        #1;
        check("rst_mid_valid", cmd_valid, 0);
        check("rst_mid_cmd", cmd, CMD_NOP);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", req_ready, 0);
        check("rst_mid_fields", {cmd_bg, cmd_ba, cmd_row, cmd_col}, 0);
        step(); step();
        rst = 1'b0;
        #1 check("rst_rel_ready_before", req_ready, 0);
        step();
        check("rst_rel_ready_after", req_ready, 1);
        repeat (30) step();
        check("rst_no_pre", log_e.size() - base, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_assert++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
